// File: rtl/lim_dec_countdown.sv
// Four-digit MM:SS countdown timer with load/start/pause control.
// Digits are modulo-L decrementors chained by borrow; done pulses on expiry.
module lim_dec_countdown #(
  parameter int L0 = 10,
  parameter int L1 = 6,
  parameter int L2 = 10,
  parameter int L3 = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        start_stop,
  output logic [15:0] digits,
  output logic        running,
  output logic        expired,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] K0 = 4'(L0);
  localparam logic [3:0] K1 = 4'(L1);
  localparam logic [3:0] K2 = 4'(L2);
  localparam logic [3:0] K3 = 4'(L3);

  state_t      state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic        done_q, done_d;
  logic [15:0] dec_val;
  logic [15:0] clamp_val;
  logic [4:0]  r0, r1, r2, r3;

  function automatic logic [3:0] clamp(
    input logic [3:0] v,
    input logic [3:0] k
  );
    return (v >= k) ? k - 4'd1 : v;
  endfunction

  // Returns {borrow_out, new_digit}.
  function automatic logic [4:0] dec_digit(
    input logic [3:0] d,
    input logic       bi,
    input logic [3:0] k
  );
    if (bi && d == 4'd0) return {1'b1, k - 4'd1};
    return {1'b0, d - {3'd0, bi}};
  endfunction

  // Borrow ripple and load clamping for all four digits.
  always_comb begin
    r0 = dec_digit(digits_q[3:0],   1'b1,  K0);
    r1 = dec_digit(digits_q[7:4],   r0[4], K1);
    r2 = dec_digit(digits_q[11:8],  r1[4], K2);
    r3 = dec_digit(digits_q[15:12], r2[4], K3);
    dec_val = {r3[3:0], r2[3:0], r1[3:0], r0[3:0]};
    clamp_val = {clamp(load_val[15:12], K3),
                 clamp(load_val[11:8],  K2),
                 clamp(load_val[7:4],   K1),
                 clamp(load_val[3:0],   K0)};
  end

  // Next state: load beats start_stop beats tick.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    done_d   = 1'b0;
    if (load) begin
      digits_d = clamp_val;
      state_d  = IDLE;
    end else if (start_stop) begin
      unique case (state_q)
        IDLE:    if (digits_q != 16'd0) state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end else if (tick && state_q == RUN && digits_q != 16'd0) begin
      digits_d = dec_val;
      if (dec_val == 16'd0) begin
        done_d  = 1'b1;
        state_d = DONE;
      end
    end
  end

  // State, digit and done registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      digits_q <= 16'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      done_q   <= done_d;
    end
  end

  assign digits  = digits_q;
  assign running = (state_q == RUN);
  assign expired = (state_q == DONE);
  assign done    = done_q;

endmodule
